// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and data_mem_responder.
//   req/we/addr/wdata : access request, driven by the initiator
//   ready/rdata/err   : one-cycle completion pulse with read data and fault flag
//   busy              : responder is not idle
// master = initiator side, slave = responder side.
interface data_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input ready, rdata, err, busy);
  modport slave  (input req, we, addr, wdata, output ready, rdata, err, busy);
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset (clears FSM, outputs and memory)
//   bus         : slave side of data_mem_responder_if
//   memory3_out : live copy of word 3 (byte address 0xC)
// A request is taken only in IDLE, held in WAIT for WAIT_CYCLES extra cycles,
// then completed with a single-cycle ready pulse in RESP.
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  output logic [31:0]           memory3_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic [31:0] idx;
  logic        fault;
  logic        accept;
  logic        complete;
  logic        busy_c;

  // Index compared at full width so high address bits cannot alias into range.
  assign idx   = {2'b00, lat_addr[31:2]};
  assign fault = (lat_addr[1:0] != 2'b00) || (idx >= 32'(DEPTH));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.req) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    accept   = (state == S_IDLE) && bus.req;
    complete = (state == S_WAIT) && (cnt == 4'd0);
    busy_c   = (state != S_IDLE);
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // ready/err are high only in the cycle after the completion edge
      ready_q <= complete;
      err_q   <= complete && fault;
      if (accept) begin
        lat_we    <= bus.we;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        cnt       <= 4'(WAIT_CYCLES);
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (complete) begin
        if (fault)        rdata_q <= 32'd0;
        else if (!lat_we) rdata_q <= mem[idx[AW-1:0]];
      end
    end
  end

  // Storage; reset clears every word so an aborted write leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (complete && !fault && lat_we) begin
      mem[idx[AW-1:0]] <= lat_wdata;
    end
  end

  generate
    if (DEPTH > 3) begin : g_m3
      assign memory3_out = mem[3];
    end else begin : g_no_m3
      assign memory3_out = 32'd0;
    end
  endgenerate

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_c;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 32: number of 32-bit words in the data store.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states inserted before each access completes (legal range 0..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req  input  1  initiator access request; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; latched with req.
REQ-007 addr  input  32  byte address; latched with req.
REQ-008 wdata  input  32  write data; latched with req.
REQ-009 ready  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  read data; valid while ready=1 for a read.
REQ-011 err  output  1  access fault flag; asserted only together with ready.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 memory3_out  output  32  continuous copy of word 3 (byte address 0x0000_000C), for observation.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; state, wait counter, latched request, rdata, ready and err SHALL all be registers.
REQ-015 IDLE: req=1 at an edge SHALL latch we/addr/wdata, load the counter with WAIT_CYCLES and go to WAIT; req=0 SHALL stay in IDLE.
REQ-016 WAIT: if counter != 0, decrement and stay; if counter == 0, perform the access, set ready=1, go to RESP.
REQ-017 RESP: ready=1 for exactly that one cycle; the next edge SHALL clear ready and err and return to IDLE.
REQ-018 Latency: for a request accepted at edge E0, ready SHALL be high in the cycle between edges E0+WAIT_CYCLES+1 and E0+WAIT_CYCLES+2.
REQ-019 req SHALL be ignored in WAIT and RESP; a req held high continuously SHALL be accepted once per WAIT_CYCLES+3 cycles.
REQ-020 Inputs we/addr/wdata need not be held after acceptance; changes during WAIT/RESP SHALL NOT affect the access in flight.
REQ-021 Word index = addr >> 2, compared at full width against DEPTH.
REQ-022 Fault: if addr[1:0] != 0 or word index >= DEPTH, then err=1 with ready, no memory write, rdata=0.
REQ-023 Good write: the memory word SHALL update at the completion edge (the WAIT-to-RESP edge); rdata SHALL hold its previous value.
REQ-024 Good read: rdata SHALL load the addressed word at the completion edge; a write to the same word in an earlier transaction SHALL be visible.
REQ-025 rdata SHALL hold its value outside completion edges.
REQ-026 busy SHALL equal (state != IDLE).
REQ-027 memory3_out SHALL reflect word 3 in the cycle after any write to it.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, counter=0, ready=0, err=0, rdata=0 and all memory words to 0, so memory3_out=0 and busy=0.
REQ-029 Reset SHALL take priority over any in-flight access: an aborted write SHALL NOT modify memory, and no ready pulse SHALL follow.
REQ-030 req=1 in the same edge as rst=1 SHALL be ignored.

Verification
REQ-031 WAIT_CYCLES=2, write addr 0x0000_000C, wdata 0xDEADBEEF accepted at E0 -> ready=1, err=0 between E3 and E4; memory3_out=0xDEADBEEF from E3 on.
REQ-032 Read addr 0x0000_000C after REQ-031 -> rdata=0xDEADBEEF while ready=1, err=0.
REQ-033 Write addr 0x0000_0006, wdata 0x12345678 -> ready=1, err=1, rdata=0x00000000; all memory words unchanged.
REQ-034 Read addr 0x0000_0080 (index 32, DEPTH=32) -> ready=1, err=1, rdata=0x00000000.
REQ-035 req held high with alternating addresses 0x0 and 0x4 -> acceptances exactly 5 cycles apart; ready pulses exactly 1 cycle wide; busy low only in the acceptance cycles.
REQ-036 Write to 0x0000_000C accepted, then rst=1 at E1 -> busy=0 and ready=0 from E1; memory3_out stays 0; the next request completes normally.
